pixel_window_3x3: RTL and testbench

- Sits directly downstream of the static image blanking stage. Consumes its blanked 8-bit pixel stream and per-pixel valid.
- Buffers the two previous image lines and emits a registered 3x3 neighbourhood per interior pixel for the feature-detection kernels.
- Tracks row and column internally, with no frame markers. Has no backpressure: every valid pixel is accepted.

---
 rtl/pixel_window_3x3.sv | 127 ++++++++++++
 tb/tb_pixel_window_3x3.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_3x3.sv
// 3x3 sliding-window generator: two line-buffer RAMs plus a two-stage pipeline
// that emits one registered neighbourhood per interior pixel, two cycles after it arrives.
module pixel_window_3x3 #(
    parameter int IMG_WIDTH   = 800,
    parameter int IMG_HEIGHT  = 600,
    parameter int PIXEL_WIDTH = 8,
    parameter int COORD_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PIXEL_WIDTH-1:0]   pixel,
    input  logic                     valid,
    output logic [9*PIXEL_WIDTH-1:0] window,
    output logic                     window_valid,
    output logic [COORD_WIDTH-1:0]   center_row,
    output logic [COORD_WIDTH-1:0]   center_col,
    output logic                     frame_done
);

    localparam int ADDR_WIDTH = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] TWO      = COORD_WIDTH'(2);
    localparam logic [COORD_WIDTH-1:0] ONE      = COORD_WIDTH'(1);

    logic [COORD_WIDTH-1:0] r_row;
    logic [COORD_WIDTH-1:0] r_col;
    logic                   w_accept;
    logic [ADDR_WIDTH-1:0]  w_addr;

    logic [PIXEL_WIDTH-1:0] r_line1 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_line2 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_l1_rd;
    logic [PIXEL_WIDTH-1:0] r_l2_rd;

    logic                   r_s1_valid;
    logic [PIXEL_WIDTH-1:0] r_s1_pixel;
    logic [COORD_WIDTH-1:0] r_s1_row;
    logic [COORD_WIDTH-1:0] r_s1_col;

    logic [8:0][PIXEL_WIDTH-1:0] r_win_sr;
    logic [8:0][PIXEL_WIDTH-1:0] w_next_win;
    logic                        w_win_ok;

    // Anything presented while reset is high is dropped, including its RAM write.
    assign w_accept = valid & ~reset;
    assign w_addr   = r_col[ADDR_WIDTH-1:0];

    // NOTE: line buffers carry no reset; rows 0-1 of every frame overwrite them before any window reads them.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_l1_rd          <= r_line1[w_addr];
            r_l2_rd          <= r_line2[w_addr];
            r_line1[w_addr]  <= pixel;
            r_line2[w_addr]  <= r_line1[w_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_pixel <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pixel <= pixel;
                r_s1_row   <= r_row;
                r_s1_col   <= r_col;
            end
        end
    end

    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        w_next_win = r_win_sr;
        for (int wr = 0; wr < 3; wr++) begin
            w_next_win[3*wr]     = r_win_sr[3*wr + 1];
            w_next_win[3*wr + 1] = r_win_sr[3*wr + 2];
        end
        w_next_win[2] = r_l2_rd;
        w_next_win[5] = r_l1_rd;
        w_next_win[8] = r_s1_pixel;
    end

    assign w_win_ok = r_s1_valid && (r_s1_row >= TWO) && (r_s1_col >= TWO);

    // The shift register advances on every stage-1 pixel; the visible window only on interior ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_sr     <= '0;
            window       <= '0;
            window_valid <= 1'b0;
            center_row   <= '0;
            center_col   <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= w_win_ok;
            frame_done   <= r_s1_valid && (r_s1_row == LAST_ROW) && (r_s1_col == LAST_COL);
            if (r_s1_valid) begin
                r_win_sr <= w_next_win;
            end
            if (w_win_ok) begin
                window     <= w_next_win;
                center_row <= r_s1_row - ONE;
                center_col <= r_s1_col - ONE;
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Scoreboard bench for pixel_window_3x3 on an 8x6 image with p(r,c) = base + r*16 + c.
module tb_pixel_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int CW = 10;

    logic            clock = 1'b0;
    logic            reset;
    logic [PW-1:0]   pixel;
    logic            valid;
    logic [9*PW-1:0] window;
    logic            window_valid;
    logic [CW-1:0]   center_row;
    logic [CW-1:0]   center_col;
    logic            frame_done;

    pixel_window_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIXEL_WIDTH(PW),
        .COORD_WIDTH(CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pixel       (pixel),
        .valid       (valid),
        .window      (window),
        .window_valid(window_valid),
        .center_row  (center_row),
        .center_col  (center_col),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9*PW-1:0] win;
        logic [CW-1:0]   row;
        logic [CW-1:0]   col;
        logic            fd;
        int              due;
    } exp_t;

    exp_t            sb_q[$];
    logic [9*PW-1:0] seen_q[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int fd_count = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [9*PW-1:0] model_win(int base, int r, int c);
        logic [9*PW-1:0] w;
        w = '0;
        for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++)
                w[PW*(3*wr+wc) +: PW] = 8'(base + (r - 2 + wr) * 16 + (c - 2 + wc));
        return w;
    endfunction

    // Outputs are sampled on the falling edge; stimulus changes 1 time unit later.
    always @(negedge clock) begin
        if (window_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window cyc=%0d got win=%h centre=(%0d,%0d) want no window",
                         cyc, window, center_row, center_col);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({window, center_row, center_col, frame_done} !== {e.win, e.row, e.col, e.fd} || cyc != e.due) begin
                    failures++;
                    $display("FAIL window cyc=%0d got win=%h centre=(%0d,%0d) fd=%b want win=%h centre=(%0d,%0d) fd=%b cyc=%0d",
                             cyc, window, center_row, center_col, frame_done, e.win, e.row, e.col, e.fd, e.due);
                end
            end
            seen_q.push_back(window);
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_window cyc=%0d got window_valid=%b want window centre=(%0d,%0d) at cyc=%0d",
                     cyc, window_valid, e.row, e.col, e.due);
        end
        if (frame_done === 1'b1) begin
            fd_count++;
            if (window_valid !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL frame_done_alone cyc=%0d got window_valid=%b want 1", cyc, window_valid);
            end
        end
    end

    task automatic drive_pixel(input int base, input int r, input int c);
        @(negedge clock);
        #1;
        valid = 1'b1;
        pixel = 8'(base + r * 16 + c);
        if (r >= 2 && c >= 2)
            sb_q.push_back('{model_win(base, r, c), CW'(r - 1), CW'(c - 1),
                             (r == H - 1 && c == W - 1), cyc + 2});
    endtask

    task automatic drive_idle();
        @(negedge clock);
        #1;
        valid = 1'b0;
        pixel = 8'($urandom);
    endtask

    task automatic send_frame(input int base, input int gap_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while (int'($urandom_range(99)) < gap_pct) drive_idle();
                drive_pixel(base, r, c);
            end
    endtask

    task automatic drain();
        repeat (5) drive_idle();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending windows want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b1;
        pixel = 8'h5A;
        repeat (3) @(negedge clock);
        checks++;
        if ({window, window_valid, center_row, center_col, frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got win=%h wv=%b centre=(%0d,%0d) fd=%b want all 0",
                     window, window_valid, center_row, center_col, frame_done);
        end
        #1;
        reset = 1'b0;
        valid = 1'b0;
    endtask

    task automatic test_basic();
        int start = seen_q.size();
        int fd0 = fd_count;
        send_frame(0, 0);
        drain();
        checks++;
        if (seen_q.size() - start != 24) begin
            failures++;
            $display("FAIL basic_count got %0d want 24", seen_q.size() - start);
        end else begin
            checks++;
            if (seen_q[start] !== 72'h22_21_20_12_11_10_02_01_00) begin
                failures++;
                $display("FAIL basic_first got %h want 222120121110020100", seen_q[start]);
            end
            checks++;
            if (seen_q[start + 23] !== 72'h57_56_55_47_46_45_37_36_35) begin
                failures++;
                $display("FAIL basic_last got %h want 575655474645373635", seen_q[start + 23]);
            end
        end
        checks++;
        if (fd_count - fd0 != 1) begin
            failures++;
            $display("FAIL basic_frame_done got %0d pulses want 1", fd_count - fd0);
        end
    endtask

    task automatic test_row_boundary();
        int start = seen_q.size();
        send_frame(0, 0);
        drain();
        checks++;
        if (seen_q.size() - start != 24 || seen_q[start + 6] !== 72'h32_31_30_22_21_20_12_11_10) begin
            failures++;
            $display("FAIL row_boundary got count=%0d win=%h want count=24 win=323130222120121110",
                     seen_q.size() - start, (seen_q.size() - start > 6) ? seen_q[start + 6] : '0);
        end
    endtask

    task automatic test_gaps();
        int start = seen_q.size();
        int fd0 = fd_count;
        send_frame(0, 40);
        drain();
        checks++;
        if (seen_q.size() - start != 24 || fd_count - fd0 != 1) begin
            failures++;
            $display("FAIL gaps_count got windows=%0d fd=%0d want windows=24 fd=1",
                     seen_q.size() - start, fd_count - fd0);
        end
    endtask

    task automatic test_back_to_back();
        int start = seen_q.size();
        int fd0 = fd_count;
        send_frame(0, 0);
        send_frame(8'h80, 0);
        drain();
        checks++;
        if (seen_q.size() - start != 48) begin
            failures++;
            $display("FAIL b2b_count got %0d want 48", seen_q.size() - start);
        end else begin
            checks++;
            if (seen_q[start + 24] !== 72'hA2_A1_A0_92_91_90_82_81_80) begin
                failures++;
                $display("FAIL b2b_second_first got %h want a2a1a0929190828180", seen_q[start + 24]);
            end
        end
        checks++;
        if (fd_count - fd0 != 2) begin
            failures++;
            $display("FAIL b2b_frame_done got %0d pulses want 2", fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int start;
        for (int i = 0; i < 20; i++) drive_pixel(0, i / W, i % W);
        // The window for the last pixel, (2,3), is in flight and must be suppressed.
        @(negedge clock);
        #1;
        reset = 1'b1;
        valid = 1'b1;
        pixel = 8'hEE;
        sb_q.delete();
        @(negedge clock);
        checks++;
        if (window_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_inflight got window_valid=%b want 0", window_valid);
        end
        #1;
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clock);
        checks++;
        if (window_valid !== 1'b0 || center_row !== '0 || center_col !== '0) begin
            failures++;
            $display("FAIL reset_after got wv=%b centre=(%0d,%0d) want 0 (0,0)",
                     window_valid, center_row, center_col);
        end
        start = seen_q.size();
        send_frame(0, 0);
        drain();
        checks++;
        if (seen_q.size() - start != 24 || seen_q[start] !== 72'h22_21_20_12_11_10_02_01_00) begin
            failures++;
            $display("FAIL reset_fresh_frame got count=%0d first=%h want count=24 first=222120121110020100",
                     seen_q.size() - start, (seen_q.size() > start) ? seen_q[start] : '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        pixel = '0;
        test_reset();
        test_basic();
        test_row_boundary();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
